fpga_input_conditioner: RTL and testbench

- Sits between the FPGA board pins (buttons/switches) and the Logisim `main` circuit inputs (Input_1..Input_N) inside the top-level shell.
- Replaces the constant tie-offs with synchronised, debounced levels.
- Debounce timing uses the shell's existing fpgaTick from the tick generator, so debounce time tracks the Logisim clock rate.
- Also produces one-cycle rise/fall pulses per channel for edge-sensitive circuit inputs.

---
 rtl/fpga_input_conditioner.sv | 65 ++++++
 tb/tb_fpga_input_conditioner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_input_conditioner.sv
// Board-pin conditioner: two-flop synchroniser, tick-gated debounce and
// registered rise/fall pulses for each input channel.
module fpga_input_conditioner #(
  parameter int nrOfInputs  = 3,
  parameter int stableTicks = 4,
  parameter int counterBits = 8
) (
  input  logic                  fpgaGlobalClock,
  input  logic                  fpgaGlobalResetN,
  input  logic                  fpgaTick,
  input  logic [nrOfInputs-1:0] rawInputs,
  output logic [nrOfInputs-1:0] cleanInputs,
  output logic [nrOfInputs-1:0] risePulse,
  output logic [nrOfInputs-1:0] fallPulse,
  output logic                  anyChange
);

  localparam logic [counterBits-1:0] last_count = counterBits'(stableTicks - 1);

  logic [nrOfInputs-1:0]  sync1;
  logic [nrOfInputs-1:0]  sync_out;
  logic [nrOfInputs-1:0]  mismatch;
  logic [nrOfInputs-1:0]  accept;
  logic [counterBits-1:0] count [nrOfInputs];

  // A channel accepts its new level on the tick that completes the run,
  // so the pulse and the level change land on the same edge.
  always_comb begin
    mismatch = sync_out ^ cleanInputs;
    accept   = '0;
    for (int i = 0; i < nrOfInputs; i++) begin
      accept[i] = mismatch[i] && fpgaTick && (count[i] == last_count);
    end
  end

  always_ff @(posedge fpgaGlobalClock) begin
    if (!fpgaGlobalResetN) begin
      sync1       <= '0;
      sync_out    <= '0;
      cleanInputs <= '0;
      risePulse   <= '0;
      fallPulse   <= '0;
      anyChange   <= 1'b0;
      for (int i = 0; i < nrOfInputs; i++) begin
        count[i] <= '0;
      end
    end else begin
      sync1       <= rawInputs;
      sync_out    <= sync1;
      cleanInputs <= cleanInputs ^ accept;
      risePulse   <= accept & sync_out;
      fallPulse   <= accept & ~sync_out;
      anyChange   <= |accept;
      // Any return to the accepted level discards the partial run.
      for (int i = 0; i < nrOfInputs; i++) begin
        if (!mismatch[i] || accept[i]) begin
          count[i] <= '0;
        end else if (fpgaTick) begin
          count[i] <= count[i] + counterBits'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fpga_input_conditioner.sv
// Bench for fpga_input_conditioner: directed scenarios with fixed cycle
// expectations plus randomized traffic against a tick-run reference model.
module tb_fpga_input_conditioner;

  localparam int n  = 3;
  localparam int st = 4;

  logic         clk;
  logic         rstn;
  logic         tick;
  logic [n-1:0] raw_in;
  logic [n-1:0] clean_out;
  logic [n-1:0] rise_out;
  logic [n-1:0] fall_out;
  logic         any_out;

  int errors;
  int checks;

  fpga_input_conditioner #(.nrOfInputs(n), .stableTicks(st), .counterBits(8)) dut (
    .fpgaGlobalClock (clk),
    .fpgaGlobalResetN(rstn),
    .fpgaTick        (tick),
    .rawInputs       (raw_in),
    .cleanInputs     (clean_out),
    .risePulse       (rise_out),
    .fallPulse       (fall_out),
    .anyChange       (any_out)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Input reaches the debouncer two edges late; a level is accepted once
  // stableTicks ticks have been seen during one unbroken disagreement.
  logic [n-1:0] m_s1, m_s2;
  logic [n-1:0] exp_clean, exp_rise, exp_fall;
  logic         exp_any;
  int           m_run [n];
  logic [2*n-1:0] exp_q[$];
  logic [2*n-1:0] obs_q[$];

  always @(posedge clk) begin
    if (!rstn) begin
      m_s1 = '0; m_s2 = '0; exp_clean = '0; exp_rise = '0; exp_fall = '0; exp_any = 1'b0;
      for (int i = 0; i < n; i++) m_run[i] = 0;
    end else begin
      exp_rise = '0;
      exp_fall = '0;
      for (int i = 0; i < n; i++) begin
        if (m_s2[i] == exp_clean[i]) m_run[i] = 0;
        else if (tick) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == st) begin
            exp_clean[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i]) exp_rise[i] = 1'b1;
            else exp_fall[i] = 1'b1;
          end
        end
      end
      exp_any = |{exp_fall, exp_rise};
      if (exp_any) exp_q.push_back({exp_fall, exp_rise});
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
  end

  // Pulse log of the DUT, compared against exp_q at the end.
  always begin
    @(posedge clk);
    #1;
    if (any_out) obs_q.push_back({fall_out, rise_out});
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic [n-1:0] r, input logic t);
    @(negedge clk);
    raw_in = r;
    tick   = t;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) cycle(n'($urandom_range(0, 7)), 1'b1);
    checks++; if (clean_out !== '0) begin errors++; $display("FAIL reset_clean got %b want 000", clean_out); end
    checks++; if (rise_out !== '0) begin errors++; $display("FAIL reset_rise got %b want 000", rise_out); end
    checks++; if (fall_out !== '0) begin errors++; $display("FAIL reset_fall got %b want 000", fall_out); end
    checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", any_out); end
    rstn = 1'b1;
    repeat (4) cycle('0, 1'b1);
  endtask

  task automatic test_rise();
    for (int k = 1; k <= 8; k++) begin
      cycle(3'b001, 1'b1);
      checks++; if (clean_out !== (k >= 6 ? 3'b001 : 3'b000)) begin errors++; $display("FAIL rise_clean k=%0d got %b want %b", k, clean_out, (k >= 6 ? 3'b001 : 3'b000)); end
      checks++; if (rise_out !== (k == 6 ? 3'b001 : 3'b000)) begin errors++; $display("FAIL rise_pulse k=%0d got %b", k, rise_out); end
      checks++; if (any_out !== (k == 6)) begin errors++; $display("FAIL rise_any k=%0d got %b want %b", k, any_out, (k == 6)); end
      checks++; if (fall_out !== 3'b000) begin errors++; $display("FAIL rise_nofall k=%0d got %b want 000", k, fall_out); end
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 10; k++) begin
      cycle((k <= 3) ? 3'b011 : 3'b001, 1'b1);
      checks++; if (clean_out !== 3'b001) begin errors++; $display("FAIL glitch_clean k=%0d got %b want 001", k, clean_out); end
      checks++; if (any_out !== 1'b0 || rise_out !== '0) begin errors++; $display("FAIL glitch_pulse k=%0d got rise=%b any=%b want 0", k, rise_out, any_out); end
    end
  endtask

  task automatic test_fall();
    for (int k = 1; k <= 8; k++) begin
      cycle(3'b000, 1'b1);
      checks++; if (fall_out !== (k == 6 ? 3'b001 : 3'b000)) begin errors++; $display("FAIL fall_pulse k=%0d got %b", k, fall_out); end
      checks++; if (rise_out !== 3'b000) begin errors++; $display("FAIL fall_norise k=%0d got %b want 000", k, rise_out); end
      checks++; if (clean_out[0] !== (k < 6)) begin errors++; $display("FAIL fall_clean k=%0d got %b want %b", k, clean_out[0], (k < 6)); end
    end
  endtask

  task automatic test_sparse();
    int exp_k;
    int seen;
    exp_k = 0;
    seen  = 0;
    // Ticks on edges k%4==1; only edges from 3 on see the synchronised change.
    for (int k = 1; k <= 24; k++) begin
      if (k % 4 == 1 && k >= 3) begin
        seen++;
        if (seen == st && exp_k == 0) exp_k = k;
      end
    end
    for (int k = 1; k <= 24; k++) begin
      cycle(3'b100, (k % 4 == 1));
      checks++; if (clean_out[2] !== (k >= exp_k)) begin errors++; $display("FAIL sparse_clean k=%0d got %b want %b", k, clean_out[2], (k >= exp_k)); end
      checks++; if (rise_out[2] !== (k == exp_k)) begin errors++; $display("FAIL sparse_rise k=%0d got %b want %b", k, rise_out[2], (k == exp_k)); end
    end
  endtask

  task automatic test_simultaneous();
    repeat (10) cycle(3'b000, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cycle(3'b111, 1'b1);
      checks++; if (clean_out !== (k >= 6 ? 3'b111 : 3'b000)) begin errors++; $display("FAIL simul_clean k=%0d got %b", k, clean_out); end
      checks++; if (rise_out !== (k == 6 ? 3'b111 : 3'b000)) begin errors++; $display("FAIL simul_rise k=%0d got %b", k, rise_out); end
      checks++; if (any_out !== (k == 6)) begin errors++; $display("FAIL simul_any k=%0d got %b want %b", k, any_out, (k == 6)); end
    end
  endtask

  task automatic test_reset_mid();
    rstn = 1'b0;
    cycle(3'b000, 1'b1);
    rstn = 1'b1;
    repeat (3) cycle(3'b000, 1'b1);
    for (int k = 1; k <= 4; k++) cycle(3'b001, 1'b1);
    rstn = 1'b0;
    cycle(3'b001, 1'b1);
    checks++; if ({clean_out, rise_out, fall_out, any_out} !== '0) begin errors++; $display("FAIL midreset_outputs got clean=%b rise=%b fall=%b any=%b want 0", clean_out, rise_out, fall_out, any_out); end
    rstn = 1'b1;
    for (int k = 6; k <= 12; k++) begin
      cycle(3'b001, 1'b1);
      checks++; if (clean_out[0] !== (k >= 11)) begin errors++; $display("FAIL midreset_clean k=%0d got %b want %b", k, clean_out[0], (k >= 11)); end
      checks++; if (rise_out[0] !== (k == 11)) begin errors++; $display("FAIL midreset_rise k=%0d got %b want %b", k, rise_out[0], (k == 11)); end
    end
  endtask

  task automatic test_random();
    logic [n-1:0] r;
    r = raw_in;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, n-1)] ^= 1'b1;
      rstn = ($urandom_range(0, 99) != 0);
      cycle(r, 1'($urandom_range(0, 1)));
      checks++; if (clean_out !== exp_clean) begin errors++; $display("FAIL rand_clean k=%0d got %b want %b", k, clean_out, exp_clean); end
      checks++; if (rise_out !== exp_rise) begin errors++; $display("FAIL rand_rise k=%0d got %b want %b", k, rise_out, exp_rise); end
      checks++; if (fall_out !== exp_fall) begin errors++; $display("FAIL rand_fall k=%0d got %b want %b", k, fall_out, exp_fall); end
      checks++; if (any_out !== exp_any) begin errors++; $display("FAIL rand_any k=%0d got %b want %b", k, any_out, exp_any); end
      checks++; if ((rise_out & fall_out) !== '0) begin errors++; $display("FAIL rand_both k=%0d got %b want 000", k, rise_out & fall_out); end
    end
    rstn = 1'b1;
    repeat (3) cycle(r, 1'b0);
  endtask

  task automatic test_pulse_log();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL pulse_log_size got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [2*n-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL pulse_log_entry got %b want %b", o, e); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn   = 1'b0;
    tick   = 1'b0;
    raw_in = '0;
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_sparse();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_pulse_log();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
